// File: rtl/serv_stoc_seq_pkg.sv
// Shared types for the stochastic ALU sequencer: FSM states, rd_sel codes, LFSR feedback masks.
package serv_stoc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [3:0] SEL_ADD  = 4'd1;
  localparam logic [3:0] SEL_SUB  = 4'd2;
  localparam logic [3:0] SEL_MULT = 4'd3;

  // Right-shifting Galois feedback masks giving a maximal-length sequence per width.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction

endpackage

// File: rtl/serv_stoc_seq_if.sv
// Command, result and ALU-facing signals of the stochastic sequencer.
interface serv_stoc_seq_if #(
  parameter int DW       = 8,
  parameter int LEN_LOG2 = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [3:0]          cmd_sel;
  logic [1:0]          cmd_bool;
  logic                cmd_matrix;
  logic [DW-1:0]       cmd_a;
  logic [DW-1:0]       cmd_b;
  logic [DW-1:0]       cmd_m;
  logic                res_valid;
  logic                res_ready;
  logic [LEN_LOG2:0]   res_count;
  logic                alu_en;
  logic [4:0]          alu_ctrl_bus;
  logic                alu_matrix_op;
  logic [2:0]          alu_cmp_ctrl;
  logic [3:0]          alu_data_bus;
  logic                alu_rd;
  logic                busy;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_bool, cmd_matrix, cmd_a, cmd_b, cmd_m, res_ready, alu_rd,
    output cmd_ready, res_valid, res_count, alu_en, alu_ctrl_bus, alu_matrix_op, alu_cmp_ctrl,
           alu_data_bus, busy
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_bool, cmd_matrix, cmd_a, cmd_b, cmd_m, res_ready, alu_rd,
    input  cmd_ready, res_valid, res_count, alu_en, alu_ctrl_bus, alu_matrix_op, alu_cmp_ctrl,
           alu_data_bus, busy
  );
endinterface

// File: rtl/serv_stoc_seq_sng.sv
// Stochastic number generator: LFSR compared against a probability gives one stream bit per cycle.
module serv_stoc_sng
  import serv_stoc_pkg::*;
#(
  parameter int          DW   = 8,
  parameter int unsigned SEED = 32'h01
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [DW-1:0] prob_i,
  output logic          bit_o
);
  localparam logic [15:0]   TAPS_W = lfsr_taps(DW);
  localparam logic [DW-1:0] TAPS   = TAPS_W[DW-1:0];
  localparam logic [DW-1:0] SEED_V = SEED[DW-1:0];

  logic [DW-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED_V;
    end else if (step_i) begin
      lfsr_d = {1'b0, lfsr_q[DW-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED_V;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // The LFSR never holds 0, so prob 0 yields all zeros and all-ones prob yields all ones.
  assign bit_o = (lfsr_q <= prob_i);

endmodule

// File: rtl/serv_stoc_seq.sv
// Sequencer: latches one op, streams 2^LEN_LOG2 operand bits into the ALU, counts ones of o_rd.
module serv_stoc_seq
  import serv_stoc_pkg::*;
#(
  parameter int          DW       = 8,
  parameter int          LEN_LOG2 = 8,
  parameter int unsigned SEED_A   = 32'h01,
  parameter int unsigned SEED_B   = 32'hA5,
  parameter int unsigned SEED_M   = 32'h3C
) (
  input  logic           clk,
  input  logic           i_rst,
  serv_stoc_seq_if.slave bus
);
  state_e              state_q;
  logic [4:0]          ctrl_q;
  logic                matrix_q;
  logic [DW-1:0]       pa_q, pb_q, pm_q;
  logic [LEN_LOG2-1:0] strm_q;
  logic                en_q, en_dly_q;
  logic [LEN_LOG2:0]   count_q;
  logic                res_vld_q;
  logic                bit_a, bit_b, bit_m;
  logic                load, step;
  logic                unused_sel;

  assign load       = (state_q == ST_LOAD);
  assign step       = (state_q == ST_RUN);
  assign unused_sel = bus.cmd_sel[3];

  serv_stoc_sng #(.DW(DW), .SEED(SEED_A)) u_sng_a (
    .clk(clk), .rst(i_rst), .load_i(load), .step_i(step), .prob_i(pa_q), .bit_o(bit_a)
  );
  serv_stoc_sng #(.DW(DW), .SEED(SEED_B)) u_sng_b (
    .clk(clk), .rst(i_rst), .load_i(load), .step_i(step), .prob_i(pb_q), .bit_o(bit_b)
  );
  serv_stoc_sng #(.DW(DW), .SEED(SEED_M)) u_sng_m (
    .clk(clk), .rst(i_rst), .load_i(load), .step_i(step), .prob_i(pm_q), .bit_o(bit_m)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      matrix_q  <= 1'b0;
      pa_q      <= '0;
      pb_q      <= '0;
      pm_q      <= '0;
      strm_q    <= '0;
      en_q      <= 1'b0;
      en_dly_q  <= 1'b0;
      count_q   <= '0;
      res_vld_q <= 1'b0;
    end else begin
      // The ALU registers o_rd, so counting follows en by one cycle.
      en_dly_q <= en_q;
      if (en_dly_q) begin
        count_q <= count_q + (LEN_LOG2+1)'(bus.alu_rd);
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            ctrl_q   <= {bus.cmd_sel[2:0], bus.cmd_bool};
            matrix_q <= bus.cmd_matrix;
            pa_q     <= bus.cmd_a;
            pb_q     <= bus.cmd_b;
            pm_q     <= bus.cmd_m;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count_q <= '0;
          strm_q  <= '0;
          en_q    <= 1'b1;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          strm_q <= strm_q + LEN_LOG2'(1);
          if (&strm_q) begin
            en_q    <= 1'b0;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          res_vld_q <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_vld_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.res_valid     = res_vld_q;
  assign bus.res_count     = count_q;
  assign bus.alu_en        = en_q;
  assign bus.alu_ctrl_bus  = ctrl_q;
  assign bus.alu_matrix_op = matrix_q;
  assign bus.alu_cmp_ctrl  = 3'b000;
  assign bus.alu_data_bus  = en_q ? {bit_a, bit_b, 1'b0, bit_m} : 4'b0000;

endmodule

// File: tb/tb_serv_stoc_seq.sv
// Directed bench for serv_stoc_seq with a small registered ALU model on the ALU side.
module tb_serv_stoc_seq;
  import serv_stoc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serv_stoc_seq_if #(.DW(8), .LEN_LOG2(8)) bus ();

  serv_stoc_seq #(
    .DW(8), .LEN_LOG2(8), .SEED_A(32'h01), .SEED_B(32'hA5), .SEED_M(32'h3C)
  ) dut (
    .clk(clk), .i_rst(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int lat;
  logic [3:0] mid_dat;
  logic       mid_en, mid_rdy, mid_busy, keep;

  // ALU model: rd registered from {rs1, opb, buf, mat}; matrix ops take mat instead of opb.
  logic alu_f, alu_y, alu_r;
  always_comb begin
    alu_r = bus.alu_data_bus[3];
    alu_y = bus.alu_matrix_op ? bus.alu_data_bus[0] : bus.alu_data_bus[2];
    case (bus.alu_ctrl_bus[4:2])
      3'd1:    alu_f = alu_r | alu_y;
      3'd2:    alu_f = alu_r & ~alu_y;
      3'd3:    alu_f = alu_r & alu_y;
      default: alu_f = 1'b0;
    endcase
  end
  always @(posedge clk or posedge rst) begin
    if (rst) bus.alu_rd <= 1'b0;
    else if (bus.alu_en) bus.alu_rd <= alu_f;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] sel, input logic [1:0] bl, input logic mx,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    bus.cmd_sel    = sel;
    bus.cmd_bool   = bl;
    bus.cmd_matrix = mx;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_m      = m;
    bus.cmd_valid  = 1'b1;
    chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Edges from the accepting edge until res_valid, with a mid-RUN snapshot.
  task automatic wait_res(output int n);
    n = 0;
    while (!bus.res_valid && n < 2000) begin
      step();
      n++;
      if (n == 10) begin
        mid_en   = bus.alu_en;
        mid_dat  = bus.alu_data_bus;
        mid_rdy  = bus.cmd_ready;
        mid_busy = bus.busy;
      end
    end
  endtask

  task automatic take();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("res_valid_cleared", {31'd0, bus.res_valid}, 32'd0);
    chk("ready_after_take", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] sel, input logic mx,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        input int exp_cnt);
    send(sel, 2'b00, mx, a, b, m);
    wait_res(lat);
    chk({tag, "_lat"}, lat, 32'd258);
    chk({tag, "_cnt"}, {23'd0, bus.res_count}, exp_cnt);
    take();
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_sel = '0; bus.cmd_bool = '0; bus.cmd_matrix = 1'b0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_m = '0; bus.res_ready = 1'b0;
    repeat (3) step();
    chk("rst_alu_en", {31'd0, bus.alu_en}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res_count", {23'd0, bus.res_count}, 32'd0);
    chk("rst_ctrl", {27'd0, bus.alu_ctrl_bus}, 32'd0);
    chk("rst_data", {28'd0, bus.alu_data_bus}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);

    // MULT of two certain streams, with bus snapshots taken mid-run.
    send(SEL_MULT, 2'b01, 1'b0, 8'd255, 8'd255, 8'd0);
    wait_res(lat);
    chk("mult_full_lat", lat, 32'd258);
    chk("mult_full_cnt", {23'd0, bus.res_count}, 32'd256);
    chk("mid_en", {31'd0, mid_en}, 32'd1);
    chk("mid_data", {28'd0, mid_dat}, 32'hC);
    chk("mid_ready", {31'd0, mid_rdy}, 32'd0);
    chk("mid_busy", {31'd0, mid_busy}, 32'd1);
    chk("ctrl_bus", {27'd0, bus.alu_ctrl_bus}, 32'h0D);
    chk("cmp_ctrl", {29'd0, bus.alu_cmp_ctrl}, 32'd0);
    chk("done_en", {31'd0, bus.alu_en}, 32'd0);
    chk("done_data", {28'd0, bus.alu_data_bus}, 32'd0);
    take();

    run_op("add_0_255", SEL_ADD, 1'b0, 8'd0, 8'd255, 8'd0, 256);
    run_op("mult_255_0", SEL_MULT, 1'b0, 8'd255, 8'd0, 8'd0, 0);
    run_op("sub_255_0", SEL_SUB, 1'b0, 8'd255, 8'd0, 8'd0, 256);

    send(SEL_MULT, 2'b00, 1'b0, 8'd128, 8'd128, 8'd0);
    wait_res(lat);
    chk("mult_half_lat", lat, 32'd258);
    chk("mult_half_range",
        {31'd0, (bus.res_count >= 9'd48) && (bus.res_count <= 9'd80)}, 32'd1);
    take();

    send(SEL_ADD, 2'b00, 1'b1, 8'd0, 8'd0, 8'd255);
    chk("matrix_op", {31'd0, bus.alu_matrix_op}, 32'd1);
    wait_res(lat);
    chk("matrix_cnt", {23'd0, bus.res_count}, 32'd256);
    take();

    send(4'b1110, 2'b11, 1'b0, 8'd255, 8'd255, 8'd255);
    chk("unused_sel_ctrl", {27'd0, bus.alu_ctrl_bus}, 32'h1B);
    wait_res(lat);
    chk("unused_sel_cnt", {23'd0, bus.res_count}, 32'd0);
    take();

    // Back-to-back: second command waits through RUN and the held result.
    send(SEL_MULT, 2'b00, 1'b0, 8'd255, 8'd255, 8'd0);
    bus.cmd_sel = SEL_ADD; bus.cmd_a = 8'd0; bus.cmd_b = 8'd255; bus.cmd_valid = 1'b1;
    wait_res(lat);
    chk("b2b_held_ready", {31'd0, mid_rdy}, 32'd0);
    chk("b2b_first_lat", lat, 32'd258);
    keep = 1'b1;
    repeat (10) begin
      step();
      if (!bus.res_valid || bus.res_count !== 9'd256 || bus.cmd_ready) keep = 1'b0;
    end
    chk("b2b_hold_stable", {31'd0, keep}, 32'd1);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("b2b_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("b2b_idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    chk("b2b_accepted", {31'd0, bus.busy}, 32'd1);
    wait_res(lat);
    chk("b2b_second_lat", lat, 32'd258);
    chk("b2b_second_cnt", {23'd0, bus.res_count}, 32'd256);
    take();

    // Reset in the middle of RUN aborts the op.
    send(SEL_MULT, 2'b00, 1'b0, 8'd255, 8'd255, 8'd0);
    repeat (100) step();
    chk("pre_abort_en", {31'd0, bus.alu_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_en", {31'd0, bus.alu_en}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_data", {28'd0, bus.alu_data_bus}, 32'd0);
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("abort_no_result", {31'd0, bus.res_valid}, 32'd0);
    run_op("post_abort", SEL_MULT, 1'b0, 8'd255, 8'd255, 8'd0, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
